ctrl_unit_pipe: RTL and testbench

//  Registered, parametrised control unit for the ID stage. Decodes mode/op_code/S into an execute/memory/writeback

---
 rtl/cu_pkg.sv | 107 ++++++++++
 rtl/cu_decode.sv | 56 +++++
 rtl/ctrl_unit_pipe.sv | 128 ++++++++++++
 tb/tb_ctrl_unit_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings, bundle type and helper functions for the ID-stage control unit.
package cu_pkg;

  localparam int unsigned EXE_CMD_W  = 4;
  localparam int unsigned LIST_MAX_W = 32;

  typedef enum logic [1:0] {
    MODE_DP    = 2'd0,
    MODE_LDST  = 2'd1,
    MODE_BR    = 2'd2,
    MODE_BLOCK = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [EXE_CMD_W-1:0] EXE_NOP = 4'd0;
  localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'd1;
  localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'd2;
  localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'd3;
  localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'd4;
  localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'd5;
  localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'd6;
  localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'd7;
  localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'd8;
  localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'd9;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  typedef struct packed {
    logic [EXE_CMD_W-1:0] exe_command;
    logic                 mem_read;
    logic                 mem_write;
    logic                 wb_enable;
    logic                 is_immediate;
    logic                 branch;
    logic                 update_status;
  } ctrl_bundle_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic int unsigned lowest_set(input logic [LIST_MAX_W-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = LIST_MAX_W - 1; i >= 0; i--) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

  // Condition test against NZCV flags (status[3]=N ... status[0]=V).
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic ok;
    n  = nzcv[3];
    z  = nzcv[2];
    c  = nzcv[1];
    v  = nzcv[0];
    ok = 1'b1;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = ~z;
      COND_CS: ok = c;
      COND_CC: ok = ~c;
      COND_MI: ok = n;
      COND_PL: ok = ~n;
      COND_VS: ok = v;
      COND_VC: ok = ~v;
      COND_HI: ok = c & ~z;
      COND_LS: ok = ~c | z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = ~z & (n == v);
      COND_LE: ok = z | (n != v);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational decoder: mode/op_code/S/imm -> execute/memory/writeback control bundle.
module cu_decode
  import cu_pkg::*;
(
  input  logic [1:0]   mode,
  input  logic [3:0]   op_code,
  input  logic         S,
  input  logic         imm,
  output ctrl_bundle_t bundle_c
);

  always_comb begin
    bundle_c = '0;
    case (mode)
      MODE_DP: begin
        bundle_c.is_immediate  = imm;
        bundle_c.update_status = S;
        bundle_c.wb_enable     = 1'b1;
        case (op_code)
          OP_MOV:  bundle_c.exe_command = EXE_MOV;
          OP_MVN:  bundle_c.exe_command = EXE_MVN;
          OP_ADD:  bundle_c.exe_command = EXE_ADD;
          OP_ADC:  bundle_c.exe_command = EXE_ADC;
          OP_SUB:  bundle_c.exe_command = EXE_SUB;
          OP_SBC:  bundle_c.exe_command = EXE_SBC;
          OP_AND:  bundle_c.exe_command = EXE_AND;
          OP_ORR:  bundle_c.exe_command = EXE_ORR;
          OP_EOR:  bundle_c.exe_command = EXE_EOR;
          OP_CMP: begin
            bundle_c.exe_command = EXE_SUB;
            bundle_c.wb_enable   = 1'b0;
          end
          OP_TST: begin
            bundle_c.exe_command = EXE_AND;
            bundle_c.wb_enable   = 1'b0;
          end
          default: begin
            bundle_c.exe_command = EXE_NOP;
            bundle_c.wb_enable   = 1'b0;
          end
        endcase
      end
      // Block-transfer beats reuse the single load/store encoding.
      MODE_LDST, MODE_BLOCK: begin
        bundle_c.exe_command  = EXE_ADD;
        bundle_c.is_immediate = imm;
        bundle_c.mem_read     = ~S;
        bundle_c.mem_write    = S;
        bundle_c.wb_enable    = ~S;
      end
      MODE_BR: bundle_c.branch = 1'b1;
      default: bundle_c = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// ID-stage control unit with valid/ready output register and LDM/STM beat expansion.
// Optional CU_COND_EXEC_EN: evaluate cond against status at acceptance and squash failing instructions.
module ctrl_unit_pipe
  import cu_pkg::*;
#(
  parameter int unsigned EXE_W      = 4,
  parameter int unsigned REG_LIST_W = 16,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned OFF_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mode,
  input  logic [3:0]            op_code,
  input  logic                  S,
  input  logic                  imm,
  input  logic [REG_LIST_W-1:0] reg_list,
  input  logic [3:0]            cond,
  input  logic [3:0]            status,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXE_W-1:0]      exe_command,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_enable,
  output logic                  is_immediate,
  output logic                  B,
  output logic                  update_status,
  output logic [IDX_W-1:0]      reg_idx,
  output logic [OFF_W-1:0]      offset
);

  state_t                  state;
  ctrl_bundle_t            bundle_q;
  ctrl_bundle_t            dec_c;
  logic [REG_LIST_W-1:0]   pending;
  logic [IDX_W-1:0]        beat_cnt;
  logic                    accept_c;
  logic                    exec_ok_c;
  logic [REG_LIST_W-1:0]   list_rest_c;
  logic [REG_LIST_W-1:0]   pending_rest_c;

  cu_decode u_decode (
    .mode     (mode),
    .op_code  (op_code),
    .S        (S),
    .imm      (imm),
    .bundle_c (dec_c)
  );

`ifdef CU_COND_EXEC_EN
  assign exec_ok_c = cond_pass(cond, status);
`else
  logic unused_cond_c;
  assign unused_cond_c = ^{cond, status};
  assign exec_ok_c     = 1'b1;
`endif

  // Masks with the lowest set bit removed: what remains after the current beat.
  assign list_rest_c    = reg_list & (reg_list - REG_LIST_W'(1));
  assign pending_rest_c = pending & (pending - REG_LIST_W'(1));

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept_c = in_valid && in_ready;

  assign exe_command   = EXE_W'(bundle_q.exe_command);
  assign mem_read      = bundle_q.mem_read;
  assign mem_write     = bundle_q.mem_write;
  assign wb_enable     = bundle_q.wb_enable;
  assign is_immediate  = bundle_q.is_immediate;
  assign B             = bundle_q.branch;
  assign update_status = bundle_q.update_status;

  // Handshake, burst FSM and beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      bundle_q  <= '0;
      reg_idx   <= '0;
      offset    <= '0;
      pending   <= '0;
      beat_cnt  <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      pending   <= '0;
      beat_cnt  <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      state     <= ST_IDLE;
      bundle_q  <= '0;
      reg_idx   <= '0;
      offset    <= '0;
      pending   <= '0;
      beat_cnt  <= '0;
      if (exec_ok_c) begin
        if (mode != MODE_BLOCK) begin
          bundle_q <= dec_c;
        end else if (reg_list != '0) begin
          bundle_q <= dec_c;
          reg_idx  <= IDX_W'(lowest_set(LIST_MAX_W'(reg_list)));
          pending  <= list_rest_c;
          if (list_rest_c != '0) begin
            state    <= ST_BURST;
            beat_cnt <= IDX_W'(1);
          end
        end
      end
    end else if ((state == ST_BURST) && out_ready) begin
      reg_idx <= IDX_W'(lowest_set(LIST_MAX_W'(pending)));
      offset  <= OFF_W'({beat_cnt, 2'b00});
      pending <= pending_rest_c;
      if (pending_rest_c == '0) begin
        state    <= ST_IDLE;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + IDX_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Randomised self-checking bench for ctrl_unit_pipe against a beat-list reference model.
module tb_ctrl_unit_pipe;

  localparam int unsigned EXE_W      = 4;
  localparam int unsigned REG_LIST_W = 16;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned OFF_W      = 8;

  typedef struct packed {
    logic [3:0] exe;
    logic       mr;
    logic       mw;
    logic       wb;
    logic       imm;
    logic       b;
    logic       us;
    logic [3:0] idx;
    logic [7:0] off;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            mode;
  logic [3:0]            op_code;
  logic                  S;
  logic                  imm;
  logic [REG_LIST_W-1:0] reg_list;
  logic [3:0]            cond;
  logic [3:0]            status;
  logic                  out_valid;
  logic                  out_ready;
  logic [EXE_W-1:0]      exe_command;
  logic                  mem_read;
  logic                  mem_write;
  logic                  wb_enable;
  logic                  is_immediate;
  logic                  B;
  logic                  update_status;
  logic [IDX_W-1:0]      reg_idx;
  logic [OFF_W-1:0]      offset;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];

  ctrl_unit_pipe #(
    .EXE_W(EXE_W), .REG_LIST_W(REG_LIST_W), .IDX_W(IDX_W), .OFF_W(OFF_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .op_code(op_code), .S(S), .imm(imm), .reg_list(reg_list),
    .cond(cond), .status(status), .out_valid(out_valid), .out_ready(out_ready),
    .exe_command(exe_command), .mem_read(mem_read), .mem_write(mem_write),
    .wb_enable(wb_enable), .is_immediate(is_immediate), .B(B),
    .update_status(update_status), .reg_idx(reg_idx), .offset(offset)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t observed();
    return {exe_command, mem_read, mem_write, wb_enable, is_immediate, B, update_status, reg_idx, offset};
  endfunction

  function automatic bit cond_ok(input logic [3:0] cd, input logic [3:0] st);
`ifdef CU_COND_EXEC_EN
    bit n = st[3], z = st[2], c = st[1], v = st[0];
    case (cd)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
`else
    return (cd == cd) || (st != st);
`endif
  endfunction

  // Expected beats for one instruction, straight from the decode tables.
  task automatic build_expected(input logic [1:0] m, input logic [3:0] op, input logic s,
                                input logic im, input logic [15:0] rl,
                                input logic [3:0] cd, input logic [3:0] st);
    beat_t bt;
    int    n;
    bt = '0;
    if (!cond_ok(cd, st)) begin
      exp_q.push_back(bt);
    end else if (m == 2'd0) begin
      case (op)
        4'hD: bt.exe = 4'd1;
        4'hF: bt.exe = 4'd9;
        4'h4: bt.exe = 4'd2;
        4'h5: bt.exe = 4'd3;
        4'h2, 4'hA: bt.exe = 4'd4;
        4'h6: bt.exe = 4'd5;
        4'h0, 4'h8: bt.exe = 4'd6;
        4'hC: bt.exe = 4'd7;
        4'h1: bt.exe = 4'd8;
        default: bt.exe = 4'd0;
      endcase
      bt.wb  = (bt.exe != 4'd0) && (op != 4'hA) && (op != 4'h8);
      bt.us  = s;
      bt.imm = im;
      exp_q.push_back(bt);
    end else if (m == 2'd2) begin
      bt.b = 1'b1;
      exp_q.push_back(bt);
    end else if (m == 2'd1 || rl != 16'h0) begin
      bt.exe = 4'd2;
      bt.mr  = !s;
      bt.mw  = s;
      bt.wb  = !s;
      bt.imm = im;
      if (m == 2'd1) begin
        exp_q.push_back(bt);
      end else begin
        n = 0;
        for (int i = 0; i < 16; i++) begin
          if (rl[i]) begin
            bt.idx = 4'(i);
            bt.off = 8'(n * 4);
            exp_q.push_back(bt);
            n++;
          end
        end
      end
    end else begin
      exp_q.push_back(bt);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [3:0] op, input logic s, input logic im,
                       input logic [15:0] rl, input logic [3:0] cd, input logic [3:0] st);
    mode = m; op_code = op; S = s; imm = im; reg_list = rl; cond = cd; status = st;
  endtask

  task automatic scramble_inputs();
    drive(2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  // Present one request, then drain and check every beat it produces.
  task automatic request(input logic [1:0] m, input logic [3:0] op, input logic s, input logic im,
                         input logic [15:0] rl, input logic [3:0] cd, input logic [3:0] st,
                         input int stall_first, input bit rand_ready);
    int    cyc;
    logic  rdy;
    logic  exp_rdy;
    beat_t got;
    build_expected(m, op, s, im, rl, cd, st);
    drive(m, op, s, im, rl, cd, st);
    in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    scramble_inputs();
    cyc = 0;
    while (exp_q.size() > 0) begin
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL out_valid_beat: out_valid=%b required 1 (beats left %0d)", out_valid, exp_q.size());
        exp_q.delete();
        break;
      end
      got = observed();
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL beat: got %h required %h", got, exp_q[0]);
      end
      rdy = (cyc < stall_first) ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      out_ready = rdy;
      #1;
      exp_rdy = (exp_q.size() == 1) && rdy;
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL in_ready_burst: in_ready=%b required %b", in_ready, exp_rdy);
      end
      step();
      if (rdy) void'(exp_q.pop_front());
      cyc++;
      if (cyc > 400) begin
        n_fail++;
        $display("FAIL drain_timeout: %0d beats never accepted", exp_q.size());
        exp_q.delete();
      end
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_valid: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(2'd0, 4'h0, 1'b0, 1'b0, 16'h0, 4'hE, 4'h0);
    step(); step();
    n_checks++;
    if (out_valid !== 1'b0 || observed() !== beat_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b bundle=%h required 0/0", out_valid, observed());
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_data_proc();
    request(2'd0, 4'b0100, 1'b1, 1'b0, 16'h0, 4'hE, 4'h0, 0, 1'b0);
    request(2'd1, 4'h0, 1'b0, 1'b1, 16'h0, 4'hE, 4'h0, 0, 1'b0);
    request(2'd1, 4'h0, 1'b1, 1'b0, 16'h0, 4'hE, 4'h0, 0, 1'b0);
    request(2'd2, 4'h3, 1'b1, 1'b1, 16'h0, 4'hE, 4'h0, 0, 1'b0);
  endtask

  task automatic test_stall();
    request(2'd0, 4'b1010, 1'b1, 1'b0, 16'h0, 4'hE, 4'h0, 3, 1'b0);
  endtask

  task automatic test_burst();
    request(2'd3, 4'h0, 1'b0, 1'b0, 16'h0085, 4'hE, 4'h0, 0, 1'b0);
    request(2'd3, 4'h0, 1'b1, 1'b1, 16'h8001, 4'hE, 4'h0, 2, 1'b1);
  endtask

  task automatic test_flush();
    drive(2'd3, 4'h0, 1'b0, 1'b0, 16'h0085, 4'hE, 4'h0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || reg_idx !== 4'd2 || offset !== 8'd4) begin
      n_fail++;
      $display("FAIL flush_second_beat: valid=%b idx=%0d off=%0d required 1/2/4", out_valid, reg_idx, offset);
    end
    flush = 1'b1;
    in_valid = 1'b1;
    drive(2'd0, 4'b0100, 1'b0, 1'b0, 16'h0, 4'hE, 4'h0);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
    end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_valid: out_valid=%b required 0", out_valid);
    end
    out_ready = 1'b0;
    request(2'd0, 4'b0100, 1'b0, 1'b1, 16'h0, 4'hE, 4'h0, 0, 1'b0);
  endtask

  task automatic test_list_edges();
    request(2'd3, 4'h0, 1'b0, 1'b1, 16'h0000, 4'hE, 4'h0, 0, 1'b0);
    request(2'd3, 4'h0, 1'b1, 1'b0, 16'hFFFF, 4'hE, 4'h0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    drive(2'd3, 4'h0, 1'b0, 1'b0, 16'hFFFF, 4'hE, 4'h0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(); step();
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    rst_n = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || observed() !== beat_t'(0)) begin
      n_fail++;
      $display("FAIL reset_mid_burst: out_valid=%b bundle=%h required 0/0", out_valid, observed());
    end
    request(2'd3, 4'h0, 1'b0, 1'b0, 16'h0006, 4'hE, 4'h0, 0, 1'b0);
  endtask

  task automatic test_cond();
`ifdef CU_COND_EXEC_EN
    request(2'd0, 4'b0100, 1'b1, 1'b0, 16'h0, 4'h0, 4'b0000, 0, 1'b0);
    request(2'd2, 4'h0, 1'b0, 1'b0, 16'h0, 4'hE, 4'b0000, 0, 1'b0);
    request(2'd3, 4'h0, 1'b0, 1'b0, 16'h00F0, 4'h1, 4'b0100, 0, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [15:0] rl;
    for (int k = 0; k < 80; k++) begin
      rl = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rl = rl & 16'($urandom) & 16'($urandom);
      request(2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), rl,
              4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_data_proc();
    test_stall();
    test_burst();
    test_flush();
    test_list_edges();
    test_reset_mid_burst();
    test_cond();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
